// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared types and constants for the FP32 multiplier scheduler.
//   FP_W        - width of an FP32 operand/result
//   LAT_W       - width of the settle-latency down-counter
//   fpm_state_t - scheduler state (IDLE, EXEC, DONE)
package fpmul_pkg;

    localparam int FP_W  = 32;
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fpm_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin pick.
//   req_i  - request vector, one bit per requester
//   ptr_i  - highest-priority index; priority descends ptr, ptr+1, ... mod NUM_REQ
//   gnt_o  - one-hot grant (all-zero when nothing is requested)
//   idx_o  - encoded index of the granted requester (0 when nothing is requested)
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand;
    logic            found;

    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fpmul_scheduler.sv
// fpmul_scheduler: shares one combinational FP32 multiplier among NUM_REQ
// requesters, one operation in flight at a time.
//   req_valid/req_a/req_b/req_ready - per-requester request channel; slice i
//                                      of req_a/req_b belongs to requester i
//   mul_a/mul_b (out), mul_out (in)  - registered operands to, and product
//                                      from, the external multiplier
//   rsp_valid/rsp_ready/rsp_data/rsp_id - single response channel
//   busy     - high whenever an operation is held
//   op_count - completed responses, wraps silently
// The block moves FP words unchanged; all arithmetic is in the multiplier.
module fpmul_scheduler
    import fpmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int MUL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    input  logic [FP_W-1:0]         mul_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [FP_W-1:0]         rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [15:0]             op_count
);

    fpm_state_t       state_q,    state_d;
    logic [ID_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
    logic [FP_W-1:0]  mul_a_q,    mul_a_d;
    logic [FP_W-1:0]  mul_b_q,    mul_b_d;
    logic [FP_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q,   rsp_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lat_cnt_d  = lat_cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        op_count_d = op_count_q;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = arb_gnt;
                    mul_a_d   = req_a[int'(arb_idx)*FP_W +: FP_W];
                    mul_b_d   = req_b[int'(arb_idx)*FP_W +: FP_W];
                    rsp_id_d  = arb_idx;
                    lat_cnt_d = LAT_W'(MUL_LAT);
                    // Winner drops to lowest priority; explicit wrap keeps this
                    // correct when NUM_REQ is not a power of two.
                    rr_ptr_d  = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                // Last settle cycle: the multiplier output is valid now.
                if (lat_cnt_q == LAT_W'(1)) begin
                    rsp_data_d = mul_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                // No grant in the handshake cycle; arbitration resumes in IDLE.
                if (rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lat_cnt_q  <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lat_cnt_q  <= lat_cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            op_count_q <= op_count_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
